stack_tos_ctrl: RTL

Top-of-stack controller sitting directly upstream of the RAM-backed stack (`clk`, `rd`, `we`, `delta`, `wd`). It holds the top element in a register and accepts PUSH/POP/REPLACE/POP_REPLACE requests from the decode stage over a valid/ready handshake. It converts each request into the stack RAM's `we`/`delta`/`wd` controls and tracks depth. It also flags overflow and underflow, so the RAM stack never sees an illegal pointer move.

---
 rtl/stack_tos_ctrl.sv | 138 +++++++++++++
 1 files changed

// File: rtl/stack_tos_ctrl.sv
// Top-of-stack controller: holds the top element in a register and turns
// PUSH/POP/REPLACE/POP_REPLACE requests into RAM-backed stack pointer moves.
module stack_tos_ctrl #(
  parameter  int WIDTH = 16,
  parameter  int DEPTH = 512,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] tos,
  output logic [WIDTH-1:0] nos,
  output logic [CW-1:0]    depth,
  output logic             empty,
  output logic             full,
  output logic             overflow,
  output logic             underflow,
  input  logic             err_clr,
  output logic             ram_we,
  output logic [1:0]       ram_delta,
  output logic [WIDTH-1:0] ram_wd,
  input  logic [WIDTH-1:0] ram_rd
);

  typedef enum logic {IDLE, WAIT} state_e;
  typedef enum logic [1:0] {
    OP_REPLACE     = 2'b00,
    OP_PUSH        = 2'b01,
    OP_POP         = 2'b10,
    OP_POP_REPLACE = 2'b11
  } op_e;

  localparam logic [1:0]    DELTA_HOLD = 2'b00;
  localparam logic [1:0]    DELTA_INC  = 2'b01;
  localparam logic [1:0]    DELTA_DEC  = 2'b11;
  localparam logic [CW-1:0] DEPTH_MAX  = CW'(DEPTH);
  localparam logic [CW-1:0] ONE        = CW'(1);
  localparam logic [CW-1:0] TWO        = CW'(2);

  state_e           state, state_n;
  logic [WIDTH-1:0] tos_n;
  logic [CW-1:0]    depth_n;
  logic             overflow_n, underflow_n;
  logic             accept;

  // op_ready depends only on registered state and rst, never on op_valid.
  assign op_ready = (state == IDLE) && !rst;
  assign accept   = op_valid && op_ready;

  assign empty = (depth == '0);
  assign full  = (depth == DEPTH_MAX);
  assign nos   = (depth >= TWO) ? ram_rd : '0;

  // NOTE: every output of this block gets a default before any branch; a path
  // that leaves one unassigned would infer a latch.
  always_comb begin
    state_n     = state;
    tos_n       = tos;
    depth_n     = depth;
    overflow_n  = err_clr ? 1'b0 : overflow;
    underflow_n = err_clr ? 1'b0 : underflow;
    ram_we      = 1'b0;
    ram_delta   = DELTA_HOLD;
    ram_wd      = tos;

    if (state == WAIT) begin
      // One idle cycle lets the synchronous RAM read settle at the new pointer.
      state_n = IDLE;
    end else if (accept) begin
      unique case (op_e'(op))
        OP_PUSH: begin
          if (depth == '0) begin
            tos_n   = din;
            depth_n = ONE;
          end else if (depth == DEPTH_MAX) begin
            overflow_n = 1'b1;
          end else begin
            ram_we    = 1'b1;
            ram_delta = DELTA_INC;
            tos_n     = din;
            depth_n   = depth + ONE;
            state_n   = WAIT;
          end
        end
        OP_POP: begin
          if (depth == '0) begin
            underflow_n = 1'b1;
          end else if (depth == ONE) begin
            tos_n   = '0;
            depth_n = '0;
          end else begin
            ram_delta = DELTA_DEC;
            tos_n     = ram_rd;
            depth_n   = depth - ONE;
            state_n   = WAIT;
          end
        end
        OP_REPLACE: begin
          if (depth == '0) underflow_n = 1'b1;
          else             tos_n       = din;
        end
        OP_POP_REPLACE: begin
          if (depth < TWO) begin
            underflow_n = 1'b1;
          end else begin
            ram_delta = DELTA_DEC;
            tos_n     = din;
            depth_n   = depth - ONE;
            state_n   = WAIT;
          end
        end
        default: ;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      tos       <= '0;
      depth     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      state     <= state_n;
      tos       <= tos_n;
      depth     <= depth_n;
      overflow  <= overflow_n;
      underflow <= underflow_n;
    end
  end

endmodule
